ipv_expander: RTL and testbench
===============================

# ipv_expander

Vector-to-serial IPV transmitter. It accepts K-bit thermometer vectors over a valid/ready interface and buffers them in a small FIFO. Each vector is emitted as a K-cycle serial bit frame on `ipv_out`: ones first, then zeros. It sits upstream of the serial-to-vector IPV reducer, which rebuilds the same thermometer vector by counting ones per K-cycle frame. Both ends free-run their frame counters from reset release.

## Interface
- `K`, 4: bits per vector = cycles per frame; legal range 2..8.
- `DEPTH`, 2: input FIFO entries; legal range 1..4.
- `clk`  in  1  clock; all logic is on the rising edge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `vov_in`  in  K  vector to transmit; MSB is thermometer bit 0.
- `vov_valid`  in  1  `vov_in` is valid.
- `vov_ready`  out  1  FIFO not full. Reset value 1.
- `ipv_out`  out  1  serial IPV bit, registered. Reset value 0.
- `ipv_frame`  out  1  high on slot 0 of every frame, registered. Reset value 0.
- `thermo_err`  out  1  one-cycle pulse: the accepted vector was not a thermometer code. Reset value 0.

## Operation
- **Accept rule:** a transfer occurs at an edge where `vov_valid && vov_ready`. The vector is pushed into the FIFO.
- **`vov_ready`:** equals `!full`, derived from registered occupancy. No push is possible when full.
- **Frame counter:** `slot` counts 0..K-1 and wraps K-1 -> 0. It runs unconditionally after reset; there is no stall.
- **Frame start (edge where `slot` == 0):**
  - If the FIFO is non-empty, pop the head and load `n` = popcount(head), width $clog2(K+1).
  - If the FIFO is empty, load `n` = 0. This produces an idle frame of all zeros.
- **Frame body:** for each slot s, the registered outputs are `ipv_out` <= (s < n) and `ipv_frame` <= (s == 0).
- **Thermometer check:** a vector is legal iff its ones are contiguous from the MSB. All-zeros and all-ones are legal.
- **Illegal vectors:** `thermo_err` pulses for one cycle after acceptance. The vector is still enqueued and transmitted by popcount, so 1010 is sent as 1100.
- **Simultaneous push and pop:**
  - With the FIFO non-empty, both take effect and occupancy is unchanged.
  - With the FIFO empty, the new entry is not visible to a pop on the same edge. It waits for the next frame start.
- **Reset mid-operation:** asynchronously clears the FIFO, `slot`, `n`, and all outputs. Any partial frame is dropped. The first post-reset edge starts frame 0.

## Timing
- The first rising edge after `rst_n` deasserts produces slot 0. `ipv_frame`=1 is visible during the following cycle, and `ipv_frame` repeats every K cycles.
- **Minimum latency:** a vector accepted at edge E, with the FIFO empty and `slot`==0 due at edge E+1, has its first bit visible after E+1.
- **Maximum latency:** with an otherwise empty FIFO, accept to first bit is K edges. Each earlier entry still queued adds K edges.
- **Throughput:** one vector per K cycles. Sustained input faster than that fills the FIFO and deasserts `vov_ready`.
- `thermo_err` is visible the cycle after the accepting edge.

## Structure
- **Shared package `ipv_pkg`:**
  - default `K` constant;
  - `popcount` function;
  - `is_thermo` function;
  - slot and count width constants computed via $clog2, also used by the reducer side.
- **Sub-module `ipv_fifo`:** synchronous FIFO, parameterised by `WIDTH`=K and `DEPTH`, with push/pop/full/empty. Occupancy counter and wrapping read/write pointers; DEPTH=1 degenerates to a single register.
- **Top level:** slot counter, frame loader (`n` register), output registers, and the `thermo_err` register.

## Test plan
- **Idle after reset**, no input, K=4: `ipv_out` stays 0; `ipv_frame`=1 in cycles 1, 5, 9, ...; `vov_ready`=1 throughout.
- **Legal vector:** push 1100 while the FIFO is empty. The next frame is `ipv_out` = 1,1,0,0 and `thermo_err` stays 0. Reducer loopback returns 1100.
- **Illegal vector:** push 1010. `thermo_err` pulses one cycle after accept, and the frame is 1,1,0,0.
- **Backpressure:** with DEPTH=2, hold valid for 1111, 0000, 1000. `vov_ready` drops after two accepts, and the third is accepted on the cycle after a pop. Frames arrive in order: 1111, 0000, 1000, then idle.
- **Push at frame start:** push 1110 on the same edge as `slot`==0 with the FIFO empty. That frame is idle 0000, and the next frame is 1,1,1,0.
- **Reset mid-frame:** assert `rst_n`=0 during slot 2 of a 1111 frame with one vector queued. All outputs are 0 immediately and `vov_ready`=1. After release the queued vector is gone and the first frame is idle.

Source files
------------

// File: rtl/ipv_pkg.sv
// Shared IPV definitions used by both the expander (transmit) and the
// reducer (receive) side: default frame length, width constants and the
// thermometer helpers. Vectors handed to the helpers are left-aligned in
// a MAX_K-bit word with zero padding in the low bits.
package ipv_pkg;

    localparam int K_DEFAULT = 4;
    localparam int MAX_K     = 8;
    localparam int SLOT_W    = $clog2(K_DEFAULT);
    localparam int CNT_W     = $clog2(K_DEFAULT + 1);
    localparam int MAX_CNT_W = $clog2(MAX_K + 1);

    // Number of ones in a left-aligned vector.
    function automatic logic [MAX_CNT_W-1:0] popcount(input logic [MAX_K-1:0] v);
        logic [MAX_CNT_W-1:0] c;
        c = {MAX_CNT_W{1'b0}};
        for (int i = 0; i < MAX_K; i++) begin
            c = c + {{(MAX_CNT_W-1){1'b0}}, v[i]};
        end
        return c;
    endfunction

    // Legal thermometer code: ones contiguous from the MSB. Zero padding in
    // the low bits never changes the verdict.
    function automatic logic is_thermo(input logic [MAX_K-1:0] v);
        logic [MAX_K-1:0] ref_v;
        ref_v = ~({MAX_K{1'b1}} >> popcount(v));
        return (v == ref_v);
    endfunction

endpackage

// File: rtl/ipv_expander_if.sv
// Vector-side valid/ready handshake feeding the IPV expander.
interface ipv_expander_if #(
    parameter int K = ipv_pkg::K_DEFAULT
) ();

    logic [K-1:0] vov_in;
    logic         vov_valid;
    logic         vov_ready;

    modport master (output vov_in, output vov_valid, input vov_ready);
    modport slave  (input vov_in, input vov_valid, output vov_ready);

endinterface

// File: rtl/ipv_fifo.sv
// Small synchronous FIFO with occupancy counter and wrapping pointers.
// Push is ignored when full and pop when empty; a push into an empty FIFO
// only becomes visible at the head on the following edge.
module ipv_fifo #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [OCC_W-1:0] count_r;
    logic             do_push_s;
    logic             do_pop_s;

    // Status flags and gated push/pop strobes from registered occupancy.
    always_comb begin
        full      = (count_r == OCC_W'(DEPTH));
        empty     = (count_r == {OCC_W{1'b0}});
        do_push_s = push && !full;
        do_pop_s  = pop && !empty;
        dout      = mem_r[rd_ptr_r];
    end

    // Storage, pointers and occupancy; DEPTH=1 keeps both pointers at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {OCC_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r <= (wr_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            if (do_pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PTR_W'(DEPTH - 1)) ? {PTR_W{1'b0}} : rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + {{(OCC_W-1){1'b0}}, 1'b1};
                2'b01:   count_r <= count_r - {{(OCC_W-1){1'b0}}, 1'b1};
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ipv_expander.sv
// Vector-to-serial IPV transmitter. Buffers accepted thermometer vectors
// and emits each one as a K-slot frame: popcount ones, then zeros. The
// slot counter free-runs from reset release; an empty FIFO at frame start
// yields an all-zero idle frame.
module ipv_expander
    import ipv_pkg::*;
#(
    parameter int K     = K_DEFAULT,
    parameter int DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    ipv_expander_if.slave      vov,
    output logic               ipv_out,
    output logic               ipv_frame,
    output logic               thermo_err
);

    localparam int SW = $clog2(K);
    localparam int CW = $clog2(K + 1);

    logic              full_s;
    logic              empty_s;
    logic              push_s;
    logic              pop_s;
    logic              frame_start_s;
    logic [K-1:0]      head_s;
    logic [MAX_K-1:0]  vec_pad_s;
    logic [MAX_K-1:0]  head_pad_s;
    logic [CW-1:0]     n_s;
    logic [SW-1:0]     slot_nxt_s;
    logic [SW-1:0]     slot_r;
    logic [CW-1:0]     n_r;
    logic              ipv_out_r;
    logic              ipv_frame_r;
    logic              thermo_err_r;

    ipv_fifo #(
        .WIDTH (K),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .din   (vov.vov_in),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign vov.vov_ready = !full_s;
    assign ipv_out       = ipv_out_r;
    assign ipv_frame     = ipv_frame_r;
    assign thermo_err    = thermo_err_r;

    // Handshake, frame-start pop and the one-count in effect for this slot.
    always_comb begin
        frame_start_s = (slot_r == {SW{1'b0}});
        push_s        = vov.vov_valid && !full_s;
        pop_s         = frame_start_s && !empty_s;
        vec_pad_s     = MAX_K'(vov.vov_in) << (MAX_K - K);
        head_pad_s    = MAX_K'(head_s) << (MAX_K - K);
        if (pop_s) begin
            n_s = CW'(popcount(head_pad_s));
        end else if (frame_start_s) begin
            n_s = {CW{1'b0}};
        end else begin
            n_s = n_r;
        end
        if (slot_r == SW'(K - 1)) begin
            slot_nxt_s = {SW{1'b0}};
        end else begin
            slot_nxt_s = slot_r + {{(SW-1){1'b0}}, 1'b1};
        end
    end

    // Slot counter, frame one-count and registered serial outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r       <= {SW{1'b0}};
            n_r          <= {CW{1'b0}};
            ipv_out_r    <= 1'b0;
            ipv_frame_r  <= 1'b0;
            thermo_err_r <= 1'b0;
        end else begin
            slot_r       <= slot_nxt_s;
            n_r          <= n_s;
            ipv_out_r    <= (CW'(slot_r) < n_s);
            ipv_frame_r  <= frame_start_s;
            thermo_err_r <= push_s && !is_thermo(vec_pad_s);
        end
    end

endmodule

// File: tb/tb_ipv_expander.sv
// Self-checking bench for ipv_expander (K=4, DEPTH=2). A queue-based
// reference model predicts every output cycle; scenario tasks add fixed
// expectations on whole captured frames.
module tb_ipv_expander;

    localparam int K     = 4;
    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ipv_out;
    logic ipv_frame;
    logic thermo_err;

    always #5 clk = ~clk;

    ipv_expander_if #(.K(K)) vif ();

    ipv_expander #(.K(K), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .vov        (vif),
        .ipv_out    (ipv_out),
        .ipv_frame  (ipv_frame),
        .thermo_err (thermo_err)
    );

    int tests = 0;
    int fails = 0;

    // reference model state
    int   q[$];
    int   edge_idx = 0;
    int   n_m = 0;
    logic exp_out = 1'b0;
    logic exp_frame = 1'b0;
    logic exp_err = 1'b0;
    logic exp_ready = 1'b1;
    logic last_acc = 1'b0;

    // frame capture from observed outputs
    int cap_idx = -1;
    int cap_pat = 0;
    int got_frames[$];

    function automatic bit thermo_ok(logic [K-1:0] v);
        int i;
        i = K - 1;
        while (i >= 0 && v[i]) i--;
        while (i >= 0) begin
            if (v[i]) return 1'b0;
            i--;
        end
        return 1'b1;
    endfunction

    task automatic model_reset();
        q.delete();
        edge_idx  = 0;
        n_m       = 0;
        exp_out   = 1'b0;
        exp_frame = 1'b0;
        exp_err   = 1'b0;
        exp_ready = 1'b1;
        cap_idx   = -1;
        got_frames.delete();
    endtask

    // Predict the edge from the current inputs, advance one clock, capture.
    task automatic step();
        bit acc;
        int slot;
        acc  = vif.vov_valid && (q.size() < DEPTH);
        slot = edge_idx % K;
        if (slot == 0) begin
            if (q.size() > 0) n_m = $countones(q.pop_front());
            else n_m = 0;
        end
        exp_out   = (slot < n_m);
        exp_frame = (slot == 0);
        exp_err   = acc && !thermo_ok(vif.vov_in);
        if (acc) q.push_back(int'(vif.vov_in));
        exp_ready = (q.size() < DEPTH);
        last_acc  = acc;
        edge_idx++;
        @(posedge clk);
        #1;
        if (ipv_frame === 1'b1) begin
            cap_idx = 0;
            cap_pat = 0;
        end
        if (cap_idx >= 0) begin
            if (ipv_out === 1'b1) cap_pat |= (1 << (K - 1 - cap_idx));
            cap_idx++;
            if (cap_idx == K) begin
                got_frames.push_back(cap_pat);
                cap_idx = -1;
            end
        end
    endtask

    // Idle until the FIFO is empty and the next edge is slot 0.
    task automatic drain();
        vif.vov_valid = 1'b0;
        for (int i = 0; i < 64 && (q.size() != 0 || (edge_idx % K) != 0); i++) step();
        got_frames.delete();
    endtask

    task automatic test_reset();
        #12;
        tests++; if (ipv_out !== 1'b0) begin fails++; $display("FAIL reset ipv_out got %b exp 0", ipv_out); end
        tests++; if (ipv_frame !== 1'b0) begin fails++; $display("FAIL reset ipv_frame got %b exp 0", ipv_frame); end
        tests++; if (thermo_err !== 1'b0) begin fails++; $display("FAIL reset thermo_err got %b exp 0", thermo_err); end
        tests++; if (vif.vov_ready !== 1'b1) begin fails++; $display("FAIL reset vov_ready got %b exp 1", vif.vov_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_idle();
        for (int c = 1; c <= 12; c++) begin
            step();
            tests++; if (ipv_out !== 1'b0) begin fails++; $display("FAIL idle ipv_out cyc %0d got %b exp 0", c, ipv_out); end
            tests++; if (ipv_frame !== ((c - 1) % K == 0)) begin fails++; $display("FAIL idle ipv_frame cyc %0d got %b exp %b", c, ipv_frame, ((c - 1) % K == 0)); end
            tests++; if (vif.vov_ready !== 1'b1) begin fails++; $display("FAIL idle vov_ready cyc %0d got %b exp 1", c, vif.vov_ready); end
            tests++; if (ipv_frame !== exp_frame) begin fails++; $display("FAIL idle model_frame cyc %0d got %b exp %b", c, ipv_frame, exp_frame); end
        end
    endtask

    // Push one vector, check every cycle, return the nonzero captured frames.
    task automatic send_one(input string name, input logic [K-1:0] v, input int cycles, output int nz[$], output int err_cycle);
        int c;
        err_cycle = -1;
        vif.vov_in = v; vif.vov_valid = 1'b1;
        step();
        vif.vov_valid = 1'b0;
        for (c = 0; c < cycles; c++) begin
            if (c > 0) step();
            if (thermo_err === 1'b1 && err_cycle < 0) err_cycle = c;
            tests++; if (ipv_out !== exp_out) begin fails++; $display("FAIL %s ipv_out cyc %0d got %b exp %b", name, c, ipv_out, exp_out); end
            tests++; if (ipv_frame !== exp_frame) begin fails++; $display("FAIL %s ipv_frame cyc %0d got %b exp %b", name, c, ipv_frame, exp_frame); end
            tests++; if (thermo_err !== exp_err) begin fails++; $display("FAIL %s thermo_err cyc %0d got %b exp %b", name, c, thermo_err, exp_err); end
            tests++; if (vif.vov_ready !== exp_ready) begin fails++; $display("FAIL %s vov_ready cyc %0d got %b exp %b", name, c, vif.vov_ready, exp_ready); end
        end
        nz.delete();
        foreach (got_frames[i]) if (got_frames[i] != 0) nz.push_back(got_frames[i]);
    endtask

    task automatic test_legal();
        int nz[$];
        int err_cycle;
        int cnt;
        int rebuilt;
        drain();
        vif.vov_in = 4'b0000; vif.vov_valid = 1'b0; step();
        send_one("legal", 4'b1100, 3 * K, nz, err_cycle);
        tests++; if (nz.size() != 1) begin fails++; $display("FAIL legal frame_count got %0d exp 1", nz.size()); end
        tests++; if (nz.size() < 1 || nz[0] != 4'b1100) begin fails++; $display("FAIL legal frame got %0d frames first %b exp 1100", nz.size(), (nz.size() > 0) ? nz[0][3:0] : 4'b0000); end
        tests++; if (err_cycle != -1) begin fails++; $display("FAIL legal thermo_err pulse at %0d exp none", err_cycle); end
        cnt = (nz.size() > 0) ? $countones(nz[0]) : 0;
        rebuilt = ((1 << cnt) - 1) << (K - cnt);
        tests++; if (rebuilt != 4'b1100) begin fails++; $display("FAIL legal loopback got %b exp 1100", rebuilt[3:0]); end
    endtask

    task automatic test_illegal();
        int nz[$];
        int err_cycle;
        drain();
        send_one("illegal", 4'b1010, 3 * K, nz, err_cycle);
        tests++; if (err_cycle != 0) begin fails++; $display("FAIL illegal thermo_err pulse cycle got %0d exp 0", err_cycle); end
        tests++; if (nz.size() != 1 || nz[0] != 4'b1100) begin fails++; $display("FAIL illegal frame got %0d frames first %b exp 1100", nz.size(), (nz.size() > 0) ? nz[0][3:0] : 4'b0000); end
    endtask

    task automatic test_push_at_frame_start();
        int nz[$];
        int err_cycle;
        drain();
        send_one("frame_start", 4'b1110, 3 * K, nz, err_cycle);
        tests++; if (got_frames.size() < 2 || got_frames[0] != 0) begin fails++; $display("FAIL frame_start first frame got %0d frames exp idle 0000", got_frames.size()); end
        tests++; if (got_frames.size() < 2 || got_frames[1] != 4'b1110) begin fails++; $display("FAIL frame_start second frame got %b exp 1110", (got_frames.size() > 1) ? got_frames[1][3:0] : 4'b0000); end
    endtask

    task automatic test_backpressure();
        logic [K-1:0] vecs [3];
        int vi;
        int first;
        bit saw_low;
        int expf [4];
        vecs[0] = 4'b1111; vecs[1] = 4'b0000; vecs[2] = 4'b1000;
        expf[0] = 4'b1111; expf[1] = 4'b0000; expf[2] = 4'b1000; expf[3] = 4'b0000;
        vi = 0; saw_low = 1'b0;
        drain();
        for (int c = 0; c < 6 * K; c++) begin
            if (vi < 3) begin vif.vov_valid = 1'b1; vif.vov_in = vecs[vi]; end
            else vif.vov_valid = 1'b0;
            step();
            if (last_acc) vi++;
            if (vif.vov_ready === 1'b0) saw_low = 1'b1;
            tests++; if (vif.vov_ready !== exp_ready) begin fails++; $display("FAIL backpressure vov_ready cyc %0d got %b exp %b", c, vif.vov_ready, exp_ready); end
            tests++; if (ipv_out !== exp_out) begin fails++; $display("FAIL backpressure ipv_out cyc %0d got %b exp %b", c, ipv_out, exp_out); end
        end
        vif.vov_valid = 1'b0;
        tests++; if (!saw_low) begin fails++; $display("FAIL backpressure ready_drop got none exp drop"); end
        first = -1;
        foreach (got_frames[i]) if (first < 0 && got_frames[i] != 0) first = i;
        for (int j = 0; j < 4; j++) begin
            tests++;
            if (first < 0 || first + j >= got_frames.size() || got_frames[first + j] != expf[j]) begin
                fails++;
                $display("FAIL backpressure order frame %0d got %b exp %b", j,
                         (first >= 0 && first + j < got_frames.size()) ? got_frames[first + j][3:0] : 4'bxxxx, expf[j][3:0]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            vif.vov_valid = ($urandom_range(0, 2) != 0);
            vif.vov_in    = 4'($urandom_range(0, 15));
            step();
            tests++; if (ipv_out !== exp_out) begin fails++; $display("FAIL random ipv_out cyc %0d got %b exp %b", c, ipv_out, exp_out); end
            tests++; if (ipv_frame !== exp_frame) begin fails++; $display("FAIL random ipv_frame cyc %0d got %b exp %b", c, ipv_frame, exp_frame); end
            tests++; if (thermo_err !== exp_err) begin fails++; $display("FAIL random thermo_err cyc %0d got %b exp %b", c, thermo_err, exp_err); end
            tests++; if (vif.vov_ready !== exp_ready) begin fails++; $display("FAIL random vov_ready cyc %0d got %b exp %b", c, vif.vov_ready, exp_ready); end
        end
        vif.vov_valid = 1'b0;
    endtask

    task automatic test_reset_mid_frame();
        drain();
        for (int i = 0; i < K - 1; i++) step();
        vif.vov_valid = 1'b1; vif.vov_in = 4'b1111; step();
        vif.vov_in = 4'b1000; step();
        vif.vov_valid = 1'b0;
        step(); step();
        tests++; if (ipv_out !== 1'b1) begin fails++; $display("FAIL midreset pre ipv_out slot2 got %b exp 1", ipv_out); end
        #2 rst_n = 1'b0;
        #1;
        tests++; if (ipv_out !== 1'b0) begin fails++; $display("FAIL midreset ipv_out got %b exp 0", ipv_out); end
        tests++; if (ipv_frame !== 1'b0) begin fails++; $display("FAIL midreset ipv_frame got %b exp 0", ipv_frame); end
        tests++; if (thermo_err !== 1'b0) begin fails++; $display("FAIL midreset thermo_err got %b exp 0", thermo_err); end
        tests++; if (vif.vov_ready !== 1'b1) begin fails++; $display("FAIL midreset vov_ready got %b exp 1", vif.vov_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        for (int c = 0; c < 2 * K + 1; c++) begin
            step();
            tests++; if (ipv_out !== 1'b0) begin fails++; $display("FAIL midreset post ipv_out cyc %0d got %b exp 0", c, ipv_out); end
            tests++; if (ipv_frame !== exp_frame) begin fails++; $display("FAIL midreset post ipv_frame cyc %0d got %b exp %b", c, ipv_frame, exp_frame); end
        end
        tests++; if (got_frames.size() < 1 || got_frames[0] != 0) begin fails++; $display("FAIL midreset first frame got %0d frames exp idle 0000", got_frames.size()); end
    endtask

    initial begin
        vif.vov_valid = 1'b0;
        vif.vov_in    = {K{1'b0}};
        test_reset();
        test_idle();
        test_legal();
        test_illegal();
        test_push_at_frame_start();
        test_backpressure();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
